comparator_search: RTL and testbench

Sequential initiator that drives operand `a` of the `comparator3bit` magnitude comparator. It binary-searches for an unknown target held on operand `b` by reading back `less`/`equal`/`greater`. It sits on the requesting side of the comparator interface: one probe per cycle, and it reports the located value, or reports not-found, with a done pulse. The target is invisible to this block; it sees only the comparator's verdicts.

---
 rtl/comparator_search.sv | 132 +++++++++++++
 tb/tb_comparator_search.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/comparator_search.sv
// Binary-search initiator for a magnitude comparator: probes operand a once per cycle
// and reports the located target (or not-found) with a one-cycle done pulse.
module comparator_search #(
  parameter int WIDTH = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  output logic [WIDTH-1:0]              guess,
  input  logic                          less,
  input  logic                          equal,
  input  logic                          greater,
  output logic                          busy,
  output logic                          done,
  output logic                          found,
  output logic [WIDTH-1:0]              result,
  output logic [$clog2(WIDTH+2)-1:0]    steps
);

  localparam int SW = $clog2(WIDTH+2);
  localparam logic [WIDTH:0] MAX_V = {1'b0, {WIDTH{1'b1}}};

  typedef enum logic [1:0] {IDLE, PROBE, DONE} state_t;

  state_t          state_q, state_d;
  logic [WIDTH:0]  lo_q, lo_d, hi_q, hi_d;
  logic [WIDTH-1:0] guess_q, guess_d, result_q, result_d;
  logic [SW-1:0]   steps_q, steps_d;
  logic            busy_q, busy_d, done_q, done_d, found_q, found_d;
  logic [WIDTH:0]  lo_up, hi_dn;
  logic            hit, miss;

  // Bounds never exceed 2^WIDTH-1, so the WIDTH+1-bit sum cannot overflow.
  function automatic logic [WIDTH-1:0] midpoint(input logic [WIDTH:0] l, input logic [WIDTH:0] h);
    logic [WIDTH:0] s;
    s = l + h;
    return s[WIDTH:1];
  endfunction

  always_comb begin
    state_d  = state_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    guess_d  = guess_q;
    result_d = result_q;
    steps_d  = steps_q;
    busy_d   = busy_q;
    found_d  = found_q;
    done_d   = 1'b0;
    hit      = 1'b0;
    miss     = 1'b0;
    lo_up    = {1'b0, guess_q} + 1'b1;
    hi_dn    = {1'b0, guess_q} - 1'b1;
    case (state_q)
      IDLE: begin
        if (start) begin
          lo_d    = '0;
          hi_d    = MAX_V;
          guess_d = midpoint('0, MAX_V);
          steps_d = '0;
          found_d = 1'b0;
          busy_d  = 1'b1;
          state_d = PROBE;
        end
      end
      PROBE: begin
        steps_d = steps_q + SW'(1);
        case ({less, equal, greater})
          3'b010: hit = 1'b1;
          3'b100: begin
            if ({1'b0, guess_q} == MAX_V || lo_up > hi_q) begin
              miss = 1'b1;
            end else begin
              lo_d    = lo_up;
              guess_d = midpoint(lo_up, hi_q);
            end
          end
          3'b001: begin
            if (guess_q == '0 || lo_q > hi_dn) begin
              miss = 1'b1;
            end else begin
              hi_d    = hi_dn;
              guess_d = midpoint(lo_q, hi_dn);
            end
          end
          default: miss = 1'b1;  // no verdict or conflicting verdicts
        endcase
        if (hit || miss) begin
          found_d  = hit;
          result_d = guess_q;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      lo_q     <= '0;
      hi_q     <= '0;
      guess_q  <= '0;
      result_q <= '0;
      steps_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      found_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      guess_q  <= guess_d;
      result_q <= result_d;
      steps_q  <= steps_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      found_q  <= found_d;
    end
  end

  assign guess  = guess_q;
  assign result = result_q;
  assign steps  = steps_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign found  = found_q;

endmodule

// File: tb/tb_comparator_search.sv
// Randomized bench for comparator_search against an integer binary-search model,
// with a behavioural comparator and fault stubs selectable per search.
module tb_comparator_search;

  localparam int WIDTH = 3;
  localparam int MAXV  = (1 << WIDTH) - 1;

  logic             clk = 1'b0;
  logic             rst_n, start;
  logic [WIDTH-1:0] guess, result, target;
  logic             less, equal, greater;
  logic             busy, done, found;
  logic [2:0]       steps;
  int               mode;  // 0 real comparator, 1 always less, 2 always greater, 3 no flags, 4 less+equal

  int n_pass = 0;
  int n_total = 0;

  int exp_guess[$];
  int exp_found, exp_result, exp_steps;

  comparator_search #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .guess(guess),
    .less(less), .equal(equal), .greater(greater),
    .busy(busy), .done(done), .found(found), .result(result), .steps(steps)
  );

  always #5 clk = ~clk;

  always_comb begin
    less = 1'b0;
    equal = 1'b0;
    greater = 1'b0;
    case (mode)
      0: begin
        less = guess < target;
        equal = guess == target;
        greater = guess > target;
      end
      1: less = 1'b1;
      2: greater = 1'b1;
      4: begin
        less = 1'b1;
        equal = 1'b1;
      end
      default: ;
    endcase
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_total++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Integer binary search over [0, MAXV] driven by the same verdict source as the bench comparator.
  task automatic model(input int md, input int tgt);
    int lo, hi, g;
    bit lt, eq, gt, fin;
    lo = 0;
    hi = MAXV;
    g = (lo + hi) / 2;
    exp_guess.delete();
    exp_steps = 0;
    exp_found = 0;
    fin = 0;
    while (!fin) begin
      exp_guess.push_back(g);
      exp_steps++;
      lt = (md == 0) ? (g < tgt) : (md == 1 || md == 4);
      eq = (md == 0) ? (g == tgt) : (md == 4);
      gt = (md == 0) ? (g > tgt) : (md == 2);
      exp_result = g;
      fin = 1;
      if (eq && !lt && !gt) exp_found = 1;
      else if (lt && !eq && !gt) begin
        if (g != MAXV && g + 1 <= hi) begin
          lo = g + 1;
          g = (lo + hi) / 2;
          fin = 0;
        end
      end else if (gt && !eq && !lt) begin
        if (g != 0 && lo <= g - 1) begin
          hi = g - 1;
          g = (lo + hi) / 2;
          fin = 0;
        end
      end
    end
  endtask

  task automatic run_search(input int md, input int tgt, input bit hold_start);
    int cyc;
    mode = md;
    target = tgt[WIDTH-1:0];
    model(md, tgt);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold_start) start = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc <= 12) begin
      check("busy", int'(busy), 1);
      if (cyc - 1 < exp_guess.size()) check("guess", int'(guess), exp_guess[cyc-1]);
      @(posedge clk);
      #1;
      cyc++;
    end
    start = 1'b0;
    check("done_cycle", cyc, exp_steps + 1);
    check("done", int'(done), 1);
    check("busy_at_done", int'(busy), 0);
    check("found", int'(found), exp_found);
    check("result", int'(result), exp_result);
    check("steps", int'(steps), exp_steps);
    @(posedge clk);
    #1;
    check("done_single", int'(done), 0);
    check("result_held", int'(result), exp_result);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    mode = 0;
    target = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_guess", int'(guess), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_found", int'(found), 0);
    check("rst_result", int'(result), 0);
    check("rst_steps", int'(steps), 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_search(0, 5, 0);
    run_search(0, 7, 0);
    run_search(0, 0, 0);
    for (int t = 0; t <= MAXV; t++) run_search(0, t, 0);
    run_search(1, 3, 0);
    run_search(2, 3, 0);
    run_search(3, 3, 0);
    run_search(4, 3, 0);
    run_search(0, 6, 1);  // start held through PROBE and DONE

    // Abort on the second probe
    mode = 0;
    target = 3'd7;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    check("abort_busy_before", int'(busy), 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("abort_guess", int'(guess), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_found", int'(found), 0);
    check("abort_result", int'(result), 0);
    check("abort_steps", int'(steps), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("abort_no_done", int'(done), 0);
    end
    run_search(0, 7, 0);

    for (int i = 0; i < 30; i++) run_search($urandom_range(0, 4), $urandom_range(0, MAXV), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
